// File: rtl/mmio_uart_ctrl_if.sv
// CPU stage-2 I/O bus plus the uart TX/RX handshakes seen by mmio_uart_ctrl.
// The master side is the CPU/uart environment; the slave side is the controller.
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  uart_data_in;
  logic        uart_data_in_valid;
  logic        uart_data_in_ready;
  logic [7:0]  uart_data_out;
  logic        uart_data_out_valid;
  logic        uart_data_out_ready;

  modport master (
    output addr, rd_en, wr_en, wdata, inst_retire,
    output uart_data_in_ready, uart_data_out, uart_data_out_valid,
    input  rdata, uart_data_in, uart_data_in_valid, uart_data_out_ready
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata, inst_retire,
    input  uart_data_in_ready, uart_data_out, uart_data_out_valid,
    output rdata, uart_data_in, uart_data_in_valid, uart_data_out_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped uart controller with RX/TX byte FIFOs and cycle/retire counters.
// Load data is registered so it arrives alongside block-RAM data in stage 3.
module mmio_uart_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mmio_uart_ctrl_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  localparam logic [5:0] W_STAT = 6'h00;
  localparam logic [5:0] W_RX   = 6'h01;
  localparam logic [5:0] W_TX   = 6'h02;
  localparam logic [5:0] W_CYC  = 6'h04;
  localparam logic [5:0] W_INS  = 6'h05;
  localparam logic [5:0] W_CLR  = 6'h06;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [7:0]  tx_mem [FIFO_DEPTH];
  ptr_t        rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic        ovr_q, ovr_d, drop_q, drop_d;
  logic [31:0] cyc_q, ins_q, rdata_q, rdata_d;

  logic        hit, rd_act, wr_act;
  logic [5:0]  widx;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic        rx_push, rx_pop, tx_push, tx_pop, tx_wr_hit, stat_rd, cnt_clr;
  logic        unused_bits;

  assign hit    = (bus.addr[31:28] == 4'h8);
  assign widx   = bus.addr[7:2];
  assign rd_act = hit && bus.rd_en && !bus.wr_en;
  assign wr_act = hit && bus.wr_en;
  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.wdata[31:8]};

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  assign bus.uart_data_out_ready = !rst && !rx_full;
  assign bus.uart_data_in_valid  = !tx_empty;
  assign bus.uart_data_in        = tx_empty ? 8'h00 : tx_mem[tx_rd_q[AW-1:0]];
  assign bus.rdata               = rdata_q;

  assign rx_push   = bus.uart_data_out_valid && bus.uart_data_out_ready;
  assign rx_pop    = rd_act && (widx == W_RX) && !rx_empty;
  assign tx_wr_hit = wr_act && (widx == W_TX);
  assign tx_push   = tx_wr_hit && !tx_full;
  assign tx_pop    = bus.uart_data_in_valid && bus.uart_data_in_ready;
  assign stat_rd   = rd_act && (widx == W_STAT);
  assign cnt_clr   = wr_act && (widx == W_CLR);

  // A new event in the same cycle as a status read stays visible for the next read.
  assign ovr_d  = (ovr_q && !stat_rd) || (bus.uart_data_out_valid && rx_full);
  assign drop_d = (drop_q && !stat_rd) || (tx_wr_hit && tx_full);

  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd_en) begin
      rdata_d = '0;
      if (rd_act) begin
        case (widx)
          W_STAT:  rdata_d = {28'd0, drop_q, ovr_q, !rx_empty, !tx_full};
          W_RX:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q[AW-1:0]]};
          W_CYC:   rdata_d = cyc_q;
          W_INS:   rdata_d = ins_q;
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      ovr_q   <= 1'b0;
      drop_q  <= 1'b0;
      cyc_q   <= '0;
      ins_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + ptr_t'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + ptr_t'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + ptr_t'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + ptr_t'(1);
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
      cyc_q   <= cnt_clr ? 32'd0 : cyc_q + 32'd1;
      ins_q   <= cnt_clr ? 32'd0 : ins_q + {31'd0, bus.inst_retire};
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= bus.uart_data_out;
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= bus.wdata[7:0];
  end
endmodule
